rob_commit_unit: RTL and testbench

In-order retirement buffer between decode/dispatch and the hazard controller. It allocates one entry per dispatched instruction, records out-of-order completions by tag, and retires the head entry in program order. Retirement produces a register-writeback pulse plus the branch-commit and jump-register-commit notifications that drive misprediction recovery and JR redirect. It also reports occupancy (`full`) and per-cycle commit activity (`valid_commit`) to the front end.

---
 rtl/rob_commit_unit.sv | 180 ++++++++++++++++++
 tb/tb_rob_commit_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit_unit.sv
// In-order retirement buffer: allocates entries at dispatch, records out-of-order
// completions by tag, and retires the head entry with registered commit pulses.
module rob_commit_unit #(
  parameter int DEPTH      = 16,
  parameter int TAG_BITS   = $clog2(DEPTH),
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alloc_valid,
  input  logic                  alloc_is_branch,
  input  logic                  alloc_is_jump_reg,
  input  logic                  alloc_has_dest,
  input  logic [4:0]            alloc_dest,
  output logic [TAG_BITS-1:0]   alloc_tag,
  output logic                  full,
  input  logic                  cmpl_valid,
  input  logic [TAG_BITS-1:0]   cmpl_tag,
  input  logic [DATA_WIDTH-1:0] cmpl_value,
  input  logic                  cmpl_taken,
  input  logic [ADDR_WIDTH-1:0] cmpl_target,
  input  logic                  commit_stall,
  input  logic                  flush,
  output logic                  valid_commit,
  output logic                  commit_we,
  output logic [4:0]            commit_dest,
  output logic [DATA_WIDTH-1:0] commit_value,
  output logic                  valid_branch,
  output logic                  branch_outcome,
  output logic                  valid_jump_reg,
  output logic [ADDR_WIDTH-1:0] jump_target
);

  typedef logic [TAG_BITS:0] ptr_t;

  ptr_t headPtr_q, headPtr_d;
  ptr_t tailPtr_q, tailPtr_d;

  logic [DEPTH-1:0] entryValid_q, entryValid_d;
  logic [DEPTH-1:0] entryDone_q, entryDone_d;
  logic [DEPTH-1:0] entryBranch_q, entryBranch_d;
  logic [DEPTH-1:0] entryJr_q, entryJr_d;
  logic [DEPTH-1:0] entryHasDest_q, entryHasDest_d;
  logic [DEPTH-1:0] entryTaken_q, entryTaken_d;
  logic [4:0]            entryDest_q   [DEPTH];
  logic [4:0]            entryDest_d   [DEPTH];
  logic [DATA_WIDTH-1:0] entryValue_q  [DEPTH];
  logic [DATA_WIDTH-1:0] entryValue_d  [DEPTH];
  logic [ADDR_WIDTH-1:0] entryTarget_q [DEPTH];
  logic [ADDR_WIDTH-1:0] entryTarget_d [DEPTH];

  logic                  validCommit_q;
  logic                  commitWe_q;
  logic [4:0]            commitDest_q;
  logic [DATA_WIDTH-1:0] commitValue_q;
  logic                  validBranch_q;
  logic                  branchOutcome_q;
  logic                  validJumpReg_q;
  logic [ADDR_WIDTH-1:0] jumpTarget_q;

  logic [TAG_BITS-1:0] headIdx;
  logic [TAG_BITS-1:0] tailIdx;
  logic                allocFire;
  logic                cmplFire;
  logic                retireFire;

  assign headIdx = headPtr_q[TAG_BITS-1:0];
  assign tailIdx = tailPtr_q[TAG_BITS-1:0];

  // Full when indices match but the wrap bits differ (count == DEPTH).
  assign full = (headIdx == tailIdx) && (headPtr_q[TAG_BITS] != tailPtr_q[TAG_BITS]);
  assign alloc_tag = tailIdx;

  assign allocFire  = alloc_valid & ~full & ~flush;
  assign cmplFire   = cmpl_valid & entryValid_q[cmpl_tag] & ~flush;
  assign retireFire = entryValid_q[headIdx] & entryDone_q[headIdx] & ~commit_stall & ~flush;

  always_comb begin
    headPtr_d      = headPtr_q;
    tailPtr_d      = tailPtr_q;
    entryValid_d   = entryValid_q;
    entryDone_d    = entryDone_q;
    entryBranch_d  = entryBranch_q;
    entryJr_d      = entryJr_q;
    entryHasDest_d = entryHasDest_q;
    entryTaken_d   = entryTaken_q;
    entryDest_d    = entryDest_q;
    entryValue_d   = entryValue_q;
    entryTarget_d  = entryTarget_q;

    if (flush) begin
      entryValid_d = '0;
      entryDone_d  = '0;
      headPtr_d    = '0;
      tailPtr_d    = '0;
    end else begin
      if (cmplFire) begin
        entryDone_d[cmpl_tag]   = 1'b1;
        entryValue_d[cmpl_tag]  = cmpl_value;
        entryTaken_d[cmpl_tag]  = cmpl_taken;
        entryTarget_d[cmpl_tag] = cmpl_target;
      end
      if (retireFire) begin
        entryValid_d[headIdx] = 1'b0;
        entryDone_d[headIdx]  = 1'b0;
        headPtr_d             = headPtr_q + ptr_t'(1);
      end
      // The tail slot is never the completing or retiring entry unless the buffer is full,
      // in which case allocation is already refused.
      if (allocFire) begin
        entryValid_d[tailIdx]   = 1'b1;
        entryDone_d[tailIdx]    = 1'b0;
        entryBranch_d[tailIdx]  = alloc_is_branch;
        entryJr_d[tailIdx]      = alloc_is_jump_reg;
        entryHasDest_d[tailIdx] = alloc_has_dest;
        entryDest_d[tailIdx]    = alloc_dest;
        tailPtr_d               = tailPtr_q + ptr_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      headPtr_q    <= '0;
      tailPtr_q    <= '0;
      entryValid_q <= '0;
      entryDone_q  <= '0;
    end else begin
      headPtr_q    <= headPtr_d;
      tailPtr_q    <= tailPtr_d;
      entryValid_q <= entryValid_d;
      entryDone_q  <= entryDone_d;
    end
  end

  // Payload fields are qualified by valid/done, so they carry no reset.
  always_ff @(posedge clk) begin
    entryBranch_q  <= entryBranch_d;
    entryJr_q      <= entryJr_d;
    entryHasDest_q <= entryHasDest_d;
    entryTaken_q   <= entryTaken_d;
    entryDest_q    <= entryDest_d;
    entryValue_q   <= entryValue_d;
    entryTarget_q  <= entryTarget_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validCommit_q   <= 1'b0;
      commitWe_q      <= 1'b0;
      commitDest_q    <= '0;
      commitValue_q   <= '0;
      validBranch_q   <= 1'b0;
      branchOutcome_q <= 1'b0;
      validJumpReg_q  <= 1'b0;
      jumpTarget_q    <= '0;
    end else begin
      validCommit_q   <= retireFire;
      commitWe_q      <= retireFire & entryHasDest_q[headIdx];
      commitDest_q    <= retireFire ? entryDest_q[headIdx] : '0;
      commitValue_q   <= retireFire ? entryValue_q[headIdx] : '0;
      validBranch_q   <= retireFire & entryBranch_q[headIdx];
      branchOutcome_q <= retireFire & entryBranch_q[headIdx] & entryTaken_q[headIdx];
      // Branch takes precedence when an entry carries both flags.
      validJumpReg_q  <= retireFire & entryJr_q[headIdx] & ~entryBranch_q[headIdx];
      jumpTarget_q    <= retireFire ? entryTarget_q[headIdx] : '0;
    end
  end

  assign valid_commit   = validCommit_q;
  assign commit_we      = commitWe_q;
  assign commit_dest    = commitDest_q;
  assign commit_value   = commitValue_q;
  assign valid_branch   = validBranch_q;
  assign branch_outcome = branchOutcome_q;
  assign valid_jump_reg = validJumpReg_q;
  assign jump_target    = jumpTarget_q;

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit: ordering, stall, branch/JR, flush, full and reset.
module tb_rob_commit_unit;

  localparam int DEPTH = 16;
  localparam int TAG_BITS = 4;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic                  alloc_valid = 1'b0;
  logic                  alloc_is_branch = 1'b0;
  logic                  alloc_is_jump_reg = 1'b0;
  logic                  alloc_has_dest = 1'b0;
  logic [4:0]            alloc_dest = '0;
  logic [TAG_BITS-1:0]   alloc_tag;
  logic                  full;
  logic                  cmpl_valid = 1'b0;
  logic [TAG_BITS-1:0]   cmpl_tag = '0;
  logic [DATA_WIDTH-1:0] cmpl_value = '0;
  logic                  cmpl_taken = 1'b0;
  logic [ADDR_WIDTH-1:0] cmpl_target = '0;
  logic                  commit_stall = 1'b0;
  logic                  flush = 1'b0;
  logic                  valid_commit;
  logic                  commit_we;
  logic [4:0]            commit_dest;
  logic [DATA_WIDTH-1:0] commit_value;
  logic                  valid_branch;
  logic                  branch_outcome;
  logic                  valid_jump_reg;
  logic [ADDR_WIDTH-1:0] jump_target;

  int checkCount = 0;
  int passCount = 0;
  int failCount = 0;

  rob_commit_unit #(
    .DEPTH(DEPTH), .TAG_BITS(TAG_BITS), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_is_branch(alloc_is_branch),
    .alloc_is_jump_reg(alloc_is_jump_reg), .alloc_has_dest(alloc_has_dest),
    .alloc_dest(alloc_dest), .alloc_tag(alloc_tag), .full(full),
    .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag), .cmpl_value(cmpl_value),
    .cmpl_taken(cmpl_taken), .cmpl_target(cmpl_target),
    .commit_stall(commit_stall), .flush(flush),
    .valid_commit(valid_commit), .commit_we(commit_we), .commit_dest(commit_dest),
    .commit_value(commit_value), .valid_branch(valid_branch),
    .branch_outcome(branch_outcome), .valid_jump_reg(valid_jump_reg),
    .jump_target(jump_target)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic av, input logic br, input logic jr, input logic hd,
                               input logic [4:0] dest, input logic cv,
                               input logic [TAG_BITS-1:0] ctag, input logic [31:0] cval,
                               input logic ctaken, input logic [31:0] ctarget);
    alloc_valid       = av;
    alloc_is_branch   = br;
    alloc_is_jump_reg = jr;
    alloc_has_dest    = hd;
    alloc_dest        = dest;
    cmpl_valid        = cv;
    cmpl_tag          = ctag;
    cmpl_value        = cval;
    cmpl_taken        = ctaken;
    cmpl_target       = ctarget;
  endtask

  task automatic idleInputs();
    applyStimulus(0, 0, 0, 0, 5'd0, 0, '0, 32'd0, 0, 32'd0);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    tick();
    tick();
    checkOutput("resetValidCommit", 64'(valid_commit), 64'd0);
    checkOutput("resetFull", 64'(full), 64'd0);
    checkOutput("resetAllocTag", 64'(alloc_tag), 64'd0);
    #2 rst_n = 1'b1;
    tick();

    // Out-of-order completion, in-order retirement
    applyStimulus(1, 0, 0, 1, 5'd3, 0, 4'd0, 32'h0, 0, 32'h0);
    checkOutput("oooAllocTag0", 64'(alloc_tag), 64'd0);
    tick();
    applyStimulus(1, 0, 0, 1, 5'd4, 0, 4'd0, 32'h0, 0, 32'h0);
    checkOutput("oooAllocTag1", 64'(alloc_tag), 64'd1);
    tick();
    applyStimulus(1, 0, 0, 1, 5'd5, 0, 4'd0, 32'h0, 0, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 5'd0, 1, 4'd2, 32'h22, 0, 32'h0);
    tick();
    checkOutput("oooNoEarlyCommit", 64'(valid_commit), 64'd0);
    applyStimulus(0, 0, 0, 0, 5'd0, 1, 4'd0, 32'h00, 0, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 5'd0, 1, 4'd1, 32'h11, 0, 32'h0);
    tick();
    checkOutput("ooo0Valid", 64'(valid_commit), 64'd1);
    checkOutput("ooo0We", 64'(commit_we), 64'd1);
    checkOutput("ooo0Dest", 64'(commit_dest), 64'd3);
    checkOutput("ooo0Value", 64'(commit_value), 64'h00);
    idleInputs();
    tick();
    checkOutput("ooo1Valid", 64'(valid_commit), 64'd1);
    checkOutput("ooo1Dest", 64'(commit_dest), 64'd4);
    checkOutput("ooo1Value", 64'(commit_value), 64'h11);
    tick();
    checkOutput("ooo2Valid", 64'(valid_commit), 64'd1);
    checkOutput("ooo2Dest", 64'(commit_dest), 64'd5);
    checkOutput("ooo2Value", 64'(commit_value), 64'h22);
    tick();
    checkOutput("oooPulseEnds", 64'(valid_commit), 64'd0);

    // Stall holds a done head for three cycles
    applyStimulus(1, 0, 0, 1, 5'd7, 0, 4'd0, 32'h0, 0, 32'h0);
    checkOutput("stallAllocTag", 64'(alloc_tag), 64'd3);
    tick();
    commit_stall = 1'b1;
    applyStimulus(0, 0, 0, 0, 5'd0, 1, 4'd3, 32'h77, 0, 32'h0);
    tick();
    idleInputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("stallHold%0d", i), 64'(valid_commit), 64'd0);
    end
    commit_stall = 1'b0;
    tick();
    checkOutput("stallReleaseValid", 64'(valid_commit), 64'd1);
    checkOutput("stallReleaseDest", 64'(commit_dest), 64'd7);
    checkOutput("stallReleaseValue", 64'(commit_value), 64'h77);
    tick();
    checkOutput("stallPulseEnds", 64'(valid_commit), 64'd0);

    // Branch and JR commit (tags 4 and 5), then a branch+JR entry (tag 6)
    applyStimulus(1, 1, 0, 0, 5'd0, 0, 4'd0, 32'h0, 0, 32'h0);
    tick();
    applyStimulus(1, 0, 1, 1, 5'd31, 0, 4'd0, 32'h0, 0, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 5'd0, 1, 4'd4, 32'h0, 1, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 5'd0, 1, 4'd5, 32'h1234, 0, 32'h0040_0100);
    tick();
    checkOutput("brValidBranch", 64'(valid_branch), 64'd1);
    checkOutput("brOutcome", 64'(branch_outcome), 64'd1);
    checkOutput("brCommitWe", 64'(commit_we), 64'd0);
    checkOutput("brNotJr", 64'(valid_jump_reg), 64'd0);
    idleInputs();
    tick();
    checkOutput("jrValidJumpReg", 64'(valid_jump_reg), 64'd1);
    checkOutput("jrTarget", 64'(jump_target), 64'h0040_0100);
    checkOutput("jrNotBranch", 64'(valid_branch), 64'd0);
    checkOutput("jrDest", 64'(commit_dest), 64'd31);
    applyStimulus(1, 1, 1, 0, 5'd0, 0, 4'd0, 32'h0, 0, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 5'd0, 1, 4'd6, 32'h0, 0, 32'h0);
    tick();
    idleInputs();
    tick();
    checkOutput("bothValidBranch", 64'(valid_branch), 64'd1);
    checkOutput("bothNotJr", 64'(valid_jump_reg), 64'd0);
    checkOutput("bothOutcome", 64'(branch_outcome), 64'd0);

    // Completion to an unallocated tag (8) is ignored
    applyStimulus(1, 0, 0, 1, 5'd9, 1, 4'd8, 32'hDEAD, 0, 32'h0);
    checkOutput("invAllocTag7", 64'(alloc_tag), 64'd7);
    tick();
    applyStimulus(1, 0, 0, 1, 5'd10, 0, 4'd0, 32'h0, 0, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 5'd0, 1, 4'd7, 32'h70, 0, 32'h0);
    tick();
    idleInputs();
    tick();
    checkOutput("invRetire7", 64'(valid_commit), 64'd1);
    checkOutput("invRetire7Dest", 64'(commit_dest), 64'd9);
    tick();
    checkOutput("invTag8NotDone", 64'(valid_commit), 64'd0);

    // Flush collides with allocation, completion and a ready head (entries 8..11)
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 1, 5'(11 + i), 0, 4'd0, 32'h0, 0, 32'h0);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 5'd0, 1, 4'd8, 32'h88, 0, 32'h0);
    tick();
    flush = 1'b1;
    applyStimulus(1, 0, 0, 1, 5'd6, 1, 4'd9, 32'h99, 0, 32'h0);
    tick();
    checkOutput("flushNoCommit", 64'(valid_commit), 64'd0);
    checkOutput("flushAllocTag", 64'(alloc_tag), 64'd0);
    checkOutput("flushFull", 64'(full), 64'd0);
    flush = 1'b0;
    idleInputs();
    tick();
    checkOutput("flushAfterNoCommit", 64'(valid_commit), 64'd0);

    // Full boundary with wrap
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 0, 0, 1, 5'(i), 0, 4'd0, 32'h0, 0, 32'h0);
      tick();
    end
    checkOutput("fullSet", 64'(full), 64'd1);
    checkOutput("fullAllocTag", 64'(alloc_tag), 64'd0);
    applyStimulus(1, 0, 0, 1, 5'd20, 1, 4'd0, 32'hA0, 0, 32'h0);
    tick();
    checkOutput("fullRefusedTag", 64'(alloc_tag), 64'd0);
    checkOutput("fullStill", 64'(full), 64'd1);
    applyStimulus(1, 0, 0, 1, 5'd21, 0, 4'd0, 32'h0, 0, 32'h0);
    tick();
    checkOutput("fullRetireValid", 64'(valid_commit), 64'd1);
    checkOutput("fullRetireDest", 64'(commit_dest), 64'd0);
    checkOutput("fullRetireValue", 64'(commit_value), 64'hA0);
    checkOutput("fullCleared", 64'(full), 64'd0);
    checkOutput("fullRefusedDuringRetire", 64'(alloc_tag), 64'd0);
    applyStimulus(1, 0, 0, 1, 5'd9, 0, 4'd0, 32'h0, 0, 32'h0);
    tick();
    checkOutput("wrapAllocTag", 64'(alloc_tag), 64'd1);
    checkOutput("wrapFullAgain", 64'(full), 64'd1);

    // Asynchronous reset while a commit pulse is live
    applyStimulus(0, 0, 0, 0, 5'd0, 1, 4'd1, 32'h11, 0, 32'h0);
    tick();
    idleInputs();
    tick();
    checkOutput("preResetValid", 64'(valid_commit), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncValidCommit", 64'(valid_commit), 64'd0);
    checkOutput("asyncCommitWe", 64'(commit_we), 64'd0);
    checkOutput("asyncCommitValue", 64'(commit_value), 64'd0);
    checkOutput("asyncAllocTag", 64'(alloc_tag), 64'd0);
    checkOutput("asyncFull", 64'(full), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("postResetAllocTag", 64'(alloc_tag), 64'd0);
    checkOutput("postResetFull", 64'(full), 64'd0);
    applyStimulus(1, 0, 0, 1, 5'd1, 1, 4'd2, 32'h55, 0, 32'h0);
    tick();
    idleInputs();
    tick();
    checkOutput("postResetHeadNotDone", 64'(valid_commit), 64'd0);
    applyStimulus(0, 0, 0, 0, 5'd0, 1, 4'd0, 32'h99, 0, 32'h0);
    tick();
    idleInputs();
    tick();
    checkOutput("postResetValid", 64'(valid_commit), 64'd1);
    checkOutput("postResetDest", 64'(commit_dest), 64'd1);
    checkOutput("postResetValue", 64'(commit_value), 64'h99);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
